// File: rtl/pc_trace_reader.sv
`default_nettype none
// ============================================================================
// Module   : pc_trace_reader
// Captures retired PCs from the commit-debug stream into a circular trace
// buffer tagged sequential/discontinuous; drained by a host over valid/ready.
// Optional : PC_TRACE_DISC_ONLY_EN -- push only discontinuous PCs.
// Revision : 1.0 - initial release
// ============================================================================
module pc_trace_reader #(
    parameter int DEPTH   = 16,
    parameter int PC_STEP = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_insn_vld,
    input  logic [31:0]                i_pc_debug,
    input  logic                       i_ready,
    input  logic                       i_clr_ovf,
    output logic                       o_valid,
    output logic [31:0]                o_pc,
    output logic                       o_disc,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    output logic [15:0]                o_drop_cnt,
    output logic [31:0]                o_retired
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam int              c_LW   = c_AW + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);
    localparam logic [31:0]     c_STEP = 32'(PC_STEP);

    logic [31:0]     r_mem_pc   [DEPTH];
    logic            r_mem_disc [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic            r_overflow;
    logic [15:0]     r_drop_cnt;
    logic [31:0]     r_retired;
    logic [31:0]     r_prev_pc;
    logic            r_first;

    logic            w_disc;
    logic            w_accept;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // Sum wraps at 32 bits so 0xFFFFFFFC -> 0x00000000 counts as sequential.
    assign w_disc = r_first || (i_pc_debug != (r_prev_pc + c_STEP));

`ifdef PC_TRACE_DISC_ONLY_EN
    assign w_accept = i_insn_vld && w_disc;
`else
    assign w_accept = i_insn_vld;
`endif

    assign w_full = (r_level == c_FULL);
    assign w_pop  = (r_level != '0) && i_ready;
    // A same-cycle pop frees a slot, so a full buffer still accepts the push.
    assign w_push = w_accept && (!w_full || w_pop);
    assign w_drop = w_accept && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= i_pc_debug;
            r_mem_disc[r_wr_ptr] <= w_disc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
            if (i_clr_ovf) begin
                r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
            end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Discontinuity tracking follows every retirement, pushed or dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_retired <= '0;
            r_prev_pc <= '0;
            r_first   <= 1'b1;
        end else if (i_insn_vld) begin
            r_retired <= r_retired + 32'd1;
            r_prev_pc <= i_pc_debug;
            r_first   <= 1'b0;
        end
    end

    assign o_valid    = (r_level != '0);
    assign o_pc       = r_mem_pc[r_rd_ptr];
    assign o_disc     = r_mem_disc[r_rd_ptr];
    assign o_level    = r_level;
    assign o_overflow = r_overflow;
    assign o_drop_cnt = r_drop_cnt;
    assign o_retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_trace_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_trace_reader
// Directed self-checking bench for pc_trace_reader (DEPTH=16, PC_STEP=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_trace_reader;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        insn_vld;
    logic [31:0] pc_debug;
    logic        ready;
    logic        clr_ovf;
    logic        valid;
    logic [31:0] pc;
    logic        disc;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [31:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    pc_trace_reader #(.DEPTH(DEPTH), .PC_STEP(4)) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_insn_vld (insn_vld),
        .i_pc_debug (pc_debug),
        .i_ready    (ready),
        .i_clr_ovf  (clr_ovf),
        .o_valid    (valid),
        .o_pc       (pc),
        .o_disc     (disc),
        .o_level    (level),
        .o_overflow (overflow),
        .o_drop_cnt (drop_cnt),
        .o_retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic vld, input logic [31:0] p, input logic rdy, input logic clr);
        insn_vld = vld;
        pc_debug = p;
        ready    = rdy;
        clr_ovf  = clr;
        @(posedge clk);
        #1;
        insn_vld = 1'b0;
        pc_debug = 32'hDEAD_BEEF;
        ready    = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid); end
        n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_tests++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired got %0d want 0", retired); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        n_tests++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0);
        n_tests++; if (level !== 5'd4) begin n_fail++; $display("FAIL basic_level got %0d want 4", level); end
        n_tests++; if (retired !== 32'd4) begin n_fail++; $display("FAIL basic_retired got %0d want 4", retired); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (valid !== 1'b1 || pc !== 32'(i * 4) || disc !== (i == 0)) begin
                n_fail++;
                $display("FAIL basic_drain[%0d] got v=%0b pc=%h d=%0b want v=1 pc=%h d=%0b",
                         i, valid, pc, disc, 32'(i * 4), (i == 0));
            end
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
        end
        n_tests++; if (valid !== 1'b0 || level !== 5'd0) begin n_fail++; $display("FAIL basic_empty got v=%0b lvl=%0d want v=0 lvl=0", valid, level); end
        n_tests++; if (retired !== 32'd4) begin n_fail++; $display("FAIL basic_retired_idle got %0d want 4", retired); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0);
        cyc(1'b1, 32'h40, 1'b0, 1'b0);
        n_tests++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level got %0d want 16", level); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        n_tests++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt); end
        n_tests++; if (retired !== 32'd17) begin n_fail++; $display("FAIL ovf_retired got %0d want 17", retired); end
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (valid !== 1'b1 || pc !== 32'(i * 4) || disc !== (i == 0)) begin
                n_fail++;
                $display("FAIL ovf_contents[%0d] got v=%0b pc=%h d=%0b want v=1 pc=%h d=%0b",
                         i, valid, pc, disc, 32'(i * 4), (i == 0));
            end
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
        end
        n_tests++; if (valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after_drain got v=%0b ovf=%0b want v=0 ovf=1", valid, overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0);
        cyc(1'b1, 32'h100, 1'b1, 1'b0);
        n_tests++; if (level !== 5'd16) begin n_fail++; $display("FAIL fpp_level got %0d want 16", level); end
        n_tests++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL fpp_no_drop got ovf=%0b cnt=%0d want 0 0", overflow, drop_cnt); end
        for (int i = 1; i <= DEPTH; i++) begin
            n_tests++;
            if (i < DEPTH) begin
                if (valid !== 1'b1 || pc !== 32'(i * 4) || disc !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fpp_drain[%0d] got v=%0b pc=%h d=%0b want v=1 pc=%h d=0", i, valid, pc, disc, 32'(i * 4));
                end
            end else begin
                if (valid !== 1'b1 || pc !== 32'h100 || disc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fpp_tail got v=%0b pc=%h d=%0b want v=1 pc=00000100 d=1", valid, pc, disc);
                end
            end
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_wrap_disc();
        logic [31:0] pcs [4];
        logic        exp_d [4];
        pcs[0] = 32'hFFFF_FFF8; exp_d[0] = 1'b1;
        pcs[1] = 32'hFFFF_FFFC; exp_d[1] = 1'b0;
        pcs[2] = 32'h0000_0000; exp_d[2] = 1'b0;
        pcs[3] = 32'h0000_0010; exp_d[3] = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, pcs[i], 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (valid !== 1'b1 || pc !== pcs[i] || disc !== exp_d[i]) begin
                n_fail++;
                $display("FAIL wrap_disc[%0d] got v=%0b pc=%h d=%0b want v=1 pc=%h d=%0b", i, valid, pc, disc, pcs[i], exp_d[i]);
            end
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_clr_ovf();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0);
        cyc(1'b1, 32'h40, 1'b0, 1'b0);
        cyc(1'b1, 32'h44, 1'b0, 1'b0);
        n_tests++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL clr_pre_cnt got %0d want 2", drop_cnt); end
        cyc(1'b1, 32'h48, 1'b0, 1'b1);
        n_tests++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin n_fail++; $display("FAIL clr_with_drop got ovf=%0b cnt=%0d want 1 1", overflow, drop_cnt); end
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        n_tests++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_plain got ovf=%0b cnt=%0d want 0 0", overflow, drop_cnt); end
        n_tests++; if (retired !== 32'd19) begin n_fail++; $display("FAIL clr_retired got %0d want 19", retired); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cyc(1'b1, 32'h40, 1'b0, 1'b0);
        cyc(1'b1, 32'h44, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 32'h48, 1'b0, 1'b0);
        rst = 1'b0;
        n_tests++; if (valid !== 1'b0 || level !== 5'd0 || retired !== 32'd0) begin n_fail++; $display("FAIL midrst got v=%0b lvl=%0d ret=%0d want 0 0 0", valid, level, retired); end
        cyc(1'b1, 32'h4C, 1'b0, 1'b0);
        n_tests++; if (valid !== 1'b1 || pc !== 32'h4C || disc !== 1'b1) begin n_fail++; $display("FAIL midrst_first got v=%0b pc=%h d=%0b want v=1 pc=0000004c d=1", valid, pc, disc); end
    endtask

`ifdef PC_TRACE_DISC_ONLY_EN
    task automatic test_disc_only();
        do_reset();
        cyc(1'b1, 32'h00, 1'b0, 1'b0);
        cyc(1'b1, 32'h04, 1'b0, 1'b0);
        cyc(1'b1, 32'h08, 1'b0, 1'b0);
        cyc(1'b1, 32'h20, 1'b0, 1'b0);
        cyc(1'b1, 32'h24, 1'b0, 1'b0);
        n_tests++; if (level !== 5'd2 || retired !== 32'd5) begin n_fail++; $display("FAIL donly_level got lvl=%0d ret=%0d want 2 5", level, retired); end
        n_tests++; if (valid !== 1'b1 || pc !== 32'h00 || disc !== 1'b1) begin n_fail++; $display("FAIL donly_e0 got pc=%h d=%0b want 00000000 1", pc, disc); end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++; if (valid !== 1'b1 || pc !== 32'h20 || disc !== 1'b1) begin n_fail++; $display("FAIL donly_e1 got pc=%h d=%0b want 00000020 1", pc, disc); end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL donly_empty got v=%0b want 0", valid); end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        insn_vld = 1'b0;
        pc_debug = 32'h0;
        ready    = 1'b0;
        clr_ovf  = 1'b0;
        test_reset();
`ifdef PC_TRACE_DISC_ONLY_EN
        test_disc_only();
`else
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_wrap_disc();
        test_clr_ovf();
`endif
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_trace_reader.md
Name: pc_trace_reader

Overview:
- Consumer end of the registered commit-debug stream (instruction-valid strobe plus 32-bit debug PC) produced by the pipeline's PC/instruction debug stage.
- Captures every retired PC into a circular trace buffer and tags each entry as sequential or discontinuous.
- Counts retired instructions.
- Lets a debug host drain the buffer over a valid/ready handshake.

Parameters:
- DEPTH, 16, number of trace entries; power of two, ≥2.
- PC_STEP, 4, expected PC increment for sequential instructions.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_insn_vld  input  1  retired-instruction strobe from the debug stage.
- i_pc_debug  input  32  PC of the retired instruction; qualified by i_insn_vld.
- i_ready  input  1  host ready to accept the head entry.
- i_clr_ovf  input  1  clears o_overflow and o_drop_cnt.
- o_valid  output  1  buffer non-empty; head entry presented.
- o_pc  output  32  PC of head entry.
- o_disc  output  1  head entry is a discontinuity.
- o_level  output  $clog2(DEPTH)+1  current fill level, 0..DEPTH.
- o_overflow  output  1  sticky: at least one entry dropped.
- o_drop_cnt  output  16  entries dropped; saturates at 16'hFFFF.
- o_retired  output  32  total retired instructions; wraps modulo 2^32.

Behaviour:
- Reset (i_rst=1 at a clock edge) sets:
  - pointers = 0, o_level = 0, o_valid = 0;
  - o_overflow = 0, o_drop_cnt = 0, o_retired = 0;
  - first-flag = 1, prev_pc = 0.
- o_pc and o_disc are don't-care while o_valid = 0. Reset mid-operation discards all buffered entries.
- Push condition: i_insn_vld=1 and (level < DEPTH or pop in the same cycle).
  - The entry is {i_pc_debug, disc}, written at the write pointer, which increments modulo DEPTH.
- Pop condition: o_valid=1 and i_ready=1; the read pointer increments modulo DEPTH.
- Level update: push only +1; pop only −1; push and pop together leaves level unchanged.
  - This also applies when full, so a full buffer with a same-cycle pop accepts the push without a drop.
- Drop: i_insn_vld=1, level == DEPTH, and no pop.
  - The entry is discarded and buffer contents are unchanged.
  - o_overflow is set to 1; o_drop_cnt increments, saturating.
- Latency: an entry pushed at edge N appears on o_valid/o_pc/o_disc after edge N (visible in cycle N+1).
  - The head is read combinationally from the storage registers (first-word fall-through).
- o_valid = (level != 0).
- Discontinuity:
  - disc = 1 if first-flag = 1, else disc = (i_pc_debug != prev_pc + PC_STEP). The addition is 32-bit modulo 2^32, so 0xFFFFFFFC → 0x00000000 is sequential.
  - prev_pc <= i_pc_debug and first-flag <= 0 on every i_insn_vld=1, including dropped entries.
- o_retired increments on every i_insn_vld=1, whether the entry is pushed or dropped.
- i_clr_ovf=1: clears o_overflow and o_drop_cnt that cycle. If a drop occurs in the same cycle, the result is o_overflow=1 and o_drop_cnt=1 (the set wins).
- i_insn_vld=0: no change to buffer, prev_pc, first-flag or o_retired.
- i_pc_debug is ignored when i_insn_vld=0.

Optional Feature:
- Macro: PC_TRACE_DISC_ONLY_EN.
- Defined (compressed trace):
  - A retired instruction is pushed only if disc=1.
  - Sequential instructions still update prev_pc and o_retired but never push and never count as drops.
- Undefined: every retired instruction is pushed as described above.
- Ports are identical in both builds.

Test Plan:
1. Reset, then drive i_insn_vld with PCs 0x00,0x04,0x08,0x0C with i_ready=0 -> o_level=4, o_retired=4. Draining with i_ready=1 yields PCs in order, with o_disc=1,0,0,0.
2. Fill with DEPTH=16 sequential PCs, then one more valid at PC 0x40 with i_ready=0 -> o_level=16, o_overflow=1, o_drop_cnt=1, o_retired=17. Buffer contents unchanged.
3. Full buffer, same cycle i_insn_vld=1 with PC 0x100 and i_ready=1 -> head popped, 0x100 pushed with o_disc=1, o_level stays 16, o_overflow stays 0.
4. PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000010 -> o_disc=1,0,0,1.
5. Overflowed state with i_clr_ovf=1 and a simultaneous drop -> o_overflow=1, o_drop_cnt=1. Next cycle, i_clr_ovf=1 with no drop -> o_overflow=0, o_drop_cnt=0.
6. With PC_TRACE_DISC_ONLY_EN, PCs 0x00,0x04,0x08,0x20,0x24 -> entries 0x00 and 0x20 only, o_level=2, o_retired=5. Also assert i_rst mid-stream -> o_valid=0, o_level=0, o_retired=0 the next cycle.
